// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory read, redirect and issue-pair bundle between fetch queue and its environment
interface fetch_queue_if #(parameter int AW = 9);
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata;
  logic [15:0]   p0_IR_out;
  logic          p0_valid;
  logic [AW-1:0] p0_pc;
  logic [15:0]   p1_IR_out;
  logic          p1_valid;
  logic          fetch_next;
  logic [1:0]    issue_cnt;
  modport master (
    output redirect, redirect_pc, mem_rdata, fetch_next, issue_cnt,
    input  mem_rd, mem_addr, p0_IR_out, p0_valid, p0_pc, p1_IR_out, p1_valid
  );
  modport slave (
    input  redirect, redirect_pc, mem_rdata, fetch_next, issue_cnt,
    output mem_rd, mem_addr, p0_IR_out, p0_valid, p0_pc, p1_IR_out, p1_valid
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue instruction fetch queue feeding the decode/hazard unit
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 9
) (
  input logic        clk,
  input logic        reset_n,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic          reset_n_q, inflight, wr, v0, v1;
  logic [AW-1:0] pc;
  logic [PW-1:0] rd_ptr, wr_ptr, p1_ptr;
  logic [CW-1:0] count, cons;
  logic [1:0]    req;
  logic [15:0]   q_ir [DEPTH];
  logic [AW-1:0] q_pc [DEPTH];
  always_comb begin
    req    = !bus.fetch_next ? 2'd0 : bus.issue_cnt == 2'd3 ? 2'd2 : bus.issue_cnt;
    cons   = CW'(req) > count ? count : CW'(req);
    wr     = inflight && !bus.redirect;
    p1_ptr = rd_ptr + PW'(1);
    v0     = count != '0;
    v1     = count > CW'(1);
  end
  // credit counts the outstanding read so a returning word always has a slot
  assign bus.mem_rd    = reset_n_q && !bus.redirect &&
                         (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign bus.mem_addr  = pc;
  assign bus.p0_valid  = v0;
  assign bus.p1_valid  = v1;
  assign bus.p0_IR_out = v0 ? q_ir[rd_ptr] : '0;
  assign bus.p0_pc     = v0 ? q_pc[rd_ptr] : '0;
  assign bus.p1_IR_out = v1 ? q_ir[p1_ptr] : '0;
  always_ff @(posedge clk) reset_n_q <= reset_n;
  always_ff @(posedge clk) begin
    if (!reset_n || bus.redirect) begin
      pc       <= !reset_n ? '0 : bus.redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      pc       <= pc + AW'(bus.mem_rd);
      inflight <= bus.mem_rd;
      rd_ptr   <= rd_ptr + PW'(cons);
      wr_ptr   <= wr_ptr + PW'(wr);
      count    <= count + CW'(wr) - cons;
    end
  end
  // the returning word belongs to the address issued last cycle, i.e. pc-1
  always_ff @(posedge clk) begin
    if (wr) begin
      q_ir[wr_ptr] <= bus.mem_rdata;
      q_pc[wr_ptr] <= pc - AW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, directed corner sequences and random traffic against a queue-level model
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset_n;
  initial forever #5 clk = ~clk;
  fetch_queue_if #(.AW(9)) bus();
  fetch_queue #(.DEPTH(4), .AW(9)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  typedef struct {
    logic [15:0] ir;
    logic [8:0]  pc;
  } ent_t;
  typedef struct {
    logic rn, rdr; logic [8:0] rpc; logic fn; logic [1:0] ic;
    logic e_rd; logic [8:0] e_addr; logic e_p0v; logic [15:0] e_p0; logic [8:0] e_p0pc;
    logic e_p1v; logic [15:0] e_p1;
  } vec_t;
  ent_t mq[$];
  vec_t tbl[13];
  int checks = 0, errors = 0;
  logic m_rstq = 1'b0, m_inf = 1'b0, e_rd = 1'b0;
  logic [8:0] m_pc = '0, m_ipc = '0;
  logic p_rn, p_rdr, p_fn;
  logic [8:0] p_rpc;
  logic [1:0] p_ic;
  logic [15:0] p_rdata;
  logic rd_prev = 1'b0;
  logic [8:0] addr_prev = '0;
  bit started = 0, chk_en = 0;
  function automatic logic [15:0] mem_f(input logic [8:0] a);
    return 16'hA000 + {7'b0, a};
  endfunction
  function automatic vec_t mk(input logic rn, rdr, input logic [8:0] rpc, input logic fn,
                              input logic [1:0] ic, input logic rd, input logic [8:0] addr,
                              input logic p0v, input logic [15:0] p0, input logic [8:0] p0pc,
                              input logic p1v, input logic [15:0] p1);
    vec_t v;
    v.rn = rn; v.rdr = rdr; v.rpc = rpc; v.fn = fn; v.ic = ic;
    v.e_rd = rd; v.e_addr = addr; v.e_p0v = p0v; v.e_p0 = p0; v.e_p0pc = p0pc;
    v.e_p1v = p1v; v.e_p1 = p1;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_update();
    int n;
    if (!p_rn) begin
      mq.delete(); m_pc = '0; m_inf = 1'b0;
    end else if (p_rdr) begin
      mq.delete(); m_pc = p_rpc; m_inf = 1'b0;
    end else begin
      n = !p_fn ? 0 : (p_ic == 2'd3 ? 2 : int'(p_ic));
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (m_inf) mq.push_back('{p_rdata, m_ipc});
      m_inf = e_rd;
      if (e_rd) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 9'd1;
      end
    end
    m_rstq = p_rn;
  endtask
  task automatic compare_all();
    ent_t e0, e1;
    e0 = '{16'h0, 9'h0};
    e1 = '{16'h0, 9'h0};
    if (mq.size() > 0) e0 = mq[0];
    if (mq.size() > 1) e1 = mq[1];
    chk("mdl_mem_rd",   32'(bus.mem_rd),    32'(e_rd));
    chk("mdl_mem_addr", 32'(bus.mem_addr),  32'(m_pc));
    chk("mdl_p0_valid", 32'(bus.p0_valid),  32'(mq.size() > 0));
    chk("mdl_p0_ir",    32'(bus.p0_IR_out), 32'(e0.ir));
    chk("mdl_p0_pc",    32'(bus.p0_pc),     32'(e0.pc));
    chk("mdl_p1_valid", 32'(bus.p1_valid),  32'(mq.size() > 1));
    chk("mdl_p1_ir",    32'(bus.p1_IR_out), 32'(e1.ir));
  endtask
  task automatic cyc(input logic rn, rdr, input logic [8:0] rpc, input logic fn, input logic [1:0] ic);
    if (started) begin
      @(posedge clk);
      #1;
      model_update();
    end
    started = 1;
    p_rn = rn; p_rdr = rdr; p_rpc = rpc; p_fn = fn; p_ic = ic;
    p_rdata = rd_prev ? mem_f(addr_prev) : 16'($urandom);
    reset_n = rn;
    bus.redirect = rdr;
    bus.redirect_pc = rpc;
    bus.fetch_next = fn;
    bus.issue_cnt = ic;
    bus.mem_rdata = p_rdata;
    #2;
    e_rd = m_rstq && !p_rdr && (mq.size() + int'(m_inf) < 4);
    if (chk_en) compare_all();
    rd_prev = bus.mem_rd;
    addr_prev = bus.mem_addr;
  endtask
  initial begin
    int nxt;
    bit found;
    tbl[0]  = mk(1'b0, 1'b0, 9'h0, 1'b0, 2'd0, 1'b0, 9'h0, 1'b0, 16'h0,    9'h0, 1'b0, 16'h0);
    tbl[1]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b0, 9'h0, 1'b0, 16'h0,    9'h0, 1'b0, 16'h0);
    tbl[2]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b1, 9'h0, 1'b0, 16'h0,    9'h0, 1'b0, 16'h0);
    tbl[3]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b1, 9'h1, 1'b0, 16'h0,    9'h0, 1'b0, 16'h0);
    tbl[4]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b1, 9'h2, 1'b1, 16'hA000, 9'h0, 1'b0, 16'h0);
    tbl[5]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b1, 9'h3, 1'b1, 16'hA000, 9'h0, 1'b1, 16'hA001);
    tbl[6]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b0, 9'h4, 1'b1, 16'hA000, 9'h0, 1'b1, 16'hA001);
    tbl[7]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b0, 9'h4, 1'b1, 16'hA000, 9'h0, 1'b1, 16'hA001);
    tbl[8]  = mk(1'b1, 1'b0, 9'h0, 1'b1, 2'd2, 1'b0, 9'h4, 1'b1, 16'hA000, 9'h0, 1'b1, 16'hA001);
    tbl[9]  = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b1, 9'h4, 1'b1, 16'hA002, 9'h2, 1'b1, 16'hA003);
    tbl[10] = mk(1'b1, 1'b0, 9'h0, 1'b1, 2'd3, 1'b1, 9'h5, 1'b1, 16'hA002, 9'h2, 1'b1, 16'hA003);
    tbl[11] = mk(1'b1, 1'b0, 9'h0, 1'b1, 2'd2, 1'b1, 9'h6, 1'b1, 16'hA004, 9'h4, 1'b0, 16'h0);
    tbl[12] = mk(1'b1, 1'b0, 9'h0, 1'b0, 2'd0, 1'b1, 9'h7, 1'b1, 16'hA005, 9'h5, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 9'h0, 1'b0, 2'd0);
    chk_en = 1;
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rn, tbl[i].rdr, tbl[i].rpc, tbl[i].fn, tbl[i].ic);
      chk($sformatf("vec%0d_mem_rd", i),   32'(bus.mem_rd),    32'(tbl[i].e_rd));
      chk($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr),  32'(tbl[i].e_addr));
      chk($sformatf("vec%0d_p0_valid", i), 32'(bus.p0_valid),  32'(tbl[i].e_p0v));
      chk($sformatf("vec%0d_p0_ir", i),    32'(bus.p0_IR_out), 32'(tbl[i].e_p0));
      chk($sformatf("vec%0d_p0_pc", i),    32'(bus.p0_pc),     32'(tbl[i].e_p0pc));
      chk($sformatf("vec%0d_p1_valid", i), 32'(bus.p1_valid),  32'(tbl[i].e_p1v));
      chk($sformatf("vec%0d_p1_ir", i),    32'(bus.p1_IR_out), 32'(tbl[i].e_p1));
    end
    // steady dual issue: every word in order, one per cycle once the pipe fills
    cyc(1'b0, 1'b0, 9'h0, 1'b0, 2'd0);
    nxt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
      if (bus.p0_valid) begin
        chk("stream_p0", 32'(bus.p0_IR_out), 32'(mem_f(9'(nxt))));
        nxt++;
      end
      if (bus.p1_valid) begin
        chk("stream_p1", 32'(bus.p1_IR_out), 32'(mem_f(9'(nxt))));
        nxt++;
      end
    end
    chk("stream_throughput", 32'(nxt), 32'd37);
    // redirect exactly when the addr-5 word returns
    cyc(1'b0, 1'b0, 9'h0, 1'b0, 2'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rd_prev && addr_prev == 9'd5) begin
        cyc(1'b1, 1'b1, 9'h040, 1'b1, 2'd2);
        found = 1;
      end else cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    end
    chk("redir_hit", 32'(found), 32'd1);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("redir_empty", 32'(bus.p0_valid), 32'd0);
    chk("redir_rd", 32'(bus.mem_rd), 32'd1);
    chk("redir_addr", 32'(bus.mem_addr), 32'h040);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("redir_still_empty", 32'(bus.p0_valid), 32'd0);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("redir_p0_valid", 32'(bus.p0_valid), 32'd1);
    chk("redir_p0_pc", 32'(bus.p0_pc), 32'h040);
    chk("redir_p0_ir", 32'(bus.p0_IR_out), 32'hA040);
    // pc wrap from the top of the address space
    cyc(1'b1, 1'b1, 9'h1FF, 1'b1, 2'd2);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("wrap_addr0", 32'(bus.mem_addr), 32'h1FF);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("wrap_addr1", 32'(bus.mem_addr), 32'h000);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("wrap_pc0", 32'(bus.p0_pc), 32'h1FF);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("wrap_pc1", 32'(bus.p0_pc), 32'h000);
    cyc(1'b1, 1'b0, 9'h0, 1'b1, 2'd2);
    chk("wrap_pc2", 32'(bus.p0_pc), 32'h001);
    // reset with three queued entries and a read in flight
    cyc(1'b0, 1'b0, 9'h0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 9'h0, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 9'h0, 1'b0, 2'd0);
    chk("mid_rst_full", 32'(bus.p1_valid), 32'd1);
    cyc(1'b1, 1'b0, 9'h0, 1'b0, 2'd0);
    chk("mid_rst_rd", 32'(bus.mem_rd), 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_p0v", 32'(bus.p0_valid), 32'd0);
    chk("mid_rst_p0", 32'(bus.p0_IR_out), 32'd0);
    chk("mid_rst_p0pc", 32'(bus.p0_pc), 32'd0);
    chk("mid_rst_p1v", 32'(bus.p1_valid), 32'd0);
    chk("mid_rst_p1", 32'(bus.p1_IR_out), 32'd0);
    cyc(1'b1, 1'b0, 9'h0, 1'b0, 2'd0);
    chk("refetch_rd", 32'(bus.mem_rd), 32'd1);
    chk("refetch_addr", 32'(bus.mem_addr), 32'd0);
    cyc(1'b1, 1'b0, 9'h0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 9'h0, 1'b0, 2'd0);
    chk("refetch_p0", 32'(bus.p0_IR_out), 32'hA000);
    // random traffic against the queue model
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(63) != 0, $urandom_range(15) == 0,
          ($urandom_range(3) == 0) ? 9'h1FE : 9'($urandom), 1'($urandom), 2'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
